// File: rtl/sram_controller_if.sv
// Purpose : bundles the pipeline-side request bus and the external SRAM pins
//           of sram_controller into one interface.
// Ports   : slave modport = controller view; master modport = pipeline + SRAM side.
interface sram_controller_if;
  // Pipeline side
  logic        MEM_R_EN;     // load request from EXE/MEM
  logic        MEM_W_EN;     // store request from EXE/MEM
  logic [31:0] ALU_result;   // byte address of the access
  logic [31:0] ST_val;       // store data
  logic [31:0] read_data;    // last completed load word
  logic        ready;        // access complete or idle; freeze = ~ready
  // External SRAM side
  logic [17:0] SRAM_ADDR;    // half-word address
  logic        SRAM_WE_N;    // active-low write strobe
  logic [15:0] SRAM_DQ_out;  // write data
  logic        SRAM_DQ_oe;   // drive enable for SRAM_DQ_out
  logic [15:0] SRAM_DQ_in;   // read data, valid in the SRAM_ADDR cycle

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
    output read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
    input  read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
  );
endinterface

// File: rtl/sram_controller.sv
// Purpose : splits a 32-bit load/store into two 16-bit SRAM accesses (low half, high half).
// Latency : request seen in IDLE at cycle 0 -> ready=1 (DONE) at cycle 5; 5 frozen cycles.
// Backpr. : ready low freezes the pipeline; requests are sampled only in IDLE.
// Ports   : clk, rst (sync, active-high); bus = sram_controller_if.slave
//           (MEM_R_EN/MEM_W_EN/ALU_result/ST_val in, read_data/ready out,
//            SRAM_ADDR/SRAM_WE_N/SRAM_DQ_out/SRAM_DQ_oe out, SRAM_DQ_in in).
module sram_controller (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_wait_cnt;
  logic        w_next_wait;

  logic [31:0] r_addr;
  logic [31:0] r_st_val;
  logic        r_is_write;
  logic [31:0] r_read_data;
  logic [17:0] r_sram_addr;
  logic [15:0] r_dq_out;

  logic        w_req;
  logic [31:0] w_offset;
  logic [17:0] w_sram_addr;
  logic [15:0] w_dq_out;
  logic        w_we_n;
  logic        w_dq_oe;
  logic        w_ready;
  logic        w_unused_offset_bits;

  assign w_req    = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_offset = r_addr - 32'd1024;
  // Only offset[18:2] selects the SRAM word; the rest is dropped by design.
  assign w_unused_offset_bits = &{1'b0, w_offset[31:19], w_offset[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 1'b0;
      r_addr      <= 32'd0;
      r_st_val    <= 32'd0;
      r_is_write  <= 1'b0;
      r_read_data <= 32'd0;
      r_sram_addr <= 18'd0;
      r_dq_out    <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_next_wait;
      r_sram_addr <= w_sram_addr;
      r_dq_out    <= w_dq_out;
      if (r_state == IDLE && w_req) begin
        r_addr     <= bus.ALU_result;
        r_st_val   <= bus.ST_val;
        // A simultaneous load+store is treated as a store.
        r_is_write <= bus.MEM_W_EN;
      end
      if (r_state == ACC_LO && !r_is_write) begin
        r_read_data[15:0] <= bus.SRAM_DQ_in;
      end
      if (r_state == ACC_HI && !r_is_write) begin
        r_read_data[31:16] <= bus.SRAM_DQ_in;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_sram_addr  = r_sram_addr;   // address and data hold outside the access cycles
    w_dq_out     = r_dq_out;
    w_we_n       = 1'b1;
    w_dq_oe      = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          w_next_state = ACC_LO;
        end
      end
      ACC_LO: begin
        w_sram_addr = {w_offset[18:2], 1'b0};
        if (r_is_write) begin
          w_we_n   = 1'b0;
          w_dq_oe  = 1'b1;
          w_dq_out = r_st_val[15:0];
        end
        w_next_state = ACC_HI;
      end
      ACC_HI: begin
        w_sram_addr = {w_offset[18:2], 1'b1};
        if (r_is_write) begin
          w_we_n   = 1'b0;
          w_dq_oe  = 1'b1;
          w_dq_out = r_st_val[31:16];
        end
        w_next_wait  = 1'b0;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (r_wait_cnt) begin
          w_next_wait  = 1'b0;
          w_next_state = DONE;
        end else begin
          w_next_wait = 1'b1;
        end
      end
      DONE: begin
        w_ready      = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign bus.read_data   = r_read_data;
  assign bus.ready       = w_ready;
  assign bus.SRAM_ADDR   = w_sram_addr;
  assign bus.SRAM_DQ_out = w_dq_out;
  // Strobes are masked while rst is high so an aborted access cannot
  // commit its pending half-word at the reset edge.
  assign bus.SRAM_WE_N   = w_we_n | rst;
  assign bus.SRAM_DQ_oe  = w_dq_oe & ~rst;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sram_controller_if bus();

  sram_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous-read SRAM, written on the rising edge.
  logic [15:0] mem [0:255];
  assign bus.SRAM_DQ_in = mem[bus.SRAM_ADDR[7:0]];
  always @(posedge clk) begin
    if (!bus.SRAM_WE_N && bus.SRAM_DQ_oe) mem[bus.SRAM_ADDR[7:0]] <= bus.SRAM_DQ_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.ALU_result = 32'd0;
    bus.ST_val     = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.read_data !== 32'd0) begin
      failures++; $display("FAIL reset_read_data got=%h exp=%h", bus.read_data, 32'd0);
    end
    checks++;
    if (bus.SRAM_ADDR !== 18'd0 || bus.SRAM_DQ_out !== 16'd0) begin
      failures++; $display("FAIL reset_addr_dq got=%h/%h exp=0/0", bus.SRAM_ADDR, bus.SRAM_DQ_out);
    end
    checks++;
    if (bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0 || bus.ready !== 1'b1) begin
      failures++; $display("FAIL reset_ctrl got we_n=%b oe=%b ready=%b exp 1/0/1",
                           bus.SRAM_WE_N, bus.SRAM_DQ_oe, bus.ready);
    end
  endtask

  task automatic test_write_read();
    // Write 0xDEADBEEF to byte 1028 -> half-words 2 (low) and 3 (high).
    bus.MEM_W_EN = 1'b1; bus.ALU_result = 32'd1028; bus.ST_val = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL wr_c0_ready got=%b exp=0", bus.ready);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.SRAM_ADDR !== 18'd2 || bus.SRAM_WE_N !== 1'b0 || bus.SRAM_DQ_oe !== 1'b1 ||
        bus.SRAM_DQ_out !== 16'hBEEF) begin
      failures++; $display("FAIL wr_lo got addr=%0d we_n=%b oe=%b dq=%h exp 2/0/1/beef",
                           bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_oe, bus.SRAM_DQ_out);
    end
    tick();
    checks++;
    if (bus.SRAM_ADDR !== 18'd3 || bus.SRAM_WE_N !== 1'b0 || bus.SRAM_DQ_out !== 16'hDEAD) begin
      failures++; $display("FAIL wr_hi got addr=%0d we_n=%b dq=%h exp 3/0/dead",
                           bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_out);
    end
    for (int c = 3; c <= 4; c++) begin
      tick();
      checks++;
      if (bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0 || bus.ready !== 1'b0 ||
          bus.SRAM_ADDR !== 18'd3 || bus.SRAM_DQ_out !== 16'hDEAD) begin
        failures++; $display("FAIL wr_wait_c%0d got we_n=%b oe=%b ready=%b addr=%0d dq=%h exp 1/0/0/3/dead",
                             c, bus.SRAM_WE_N, bus.SRAM_DQ_oe, bus.ready, bus.SRAM_ADDR, bus.SRAM_DQ_out);
      end
    end
    tick();
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++; $display("FAIL wr_c5_ready got=%b exp=1", bus.ready);
    end
    checks++;
    if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
      failures++; $display("FAIL wr_mem got=%h_%h exp=dead_beef", mem[3], mem[2]);
    end
    tick();
    // Read the same word back.
    bus.MEM_R_EN = 1'b1; bus.ALU_result = 32'd1028;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.SRAM_ADDR !== 18'd2 || bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0) begin
      failures++; $display("FAIL rd_lo got addr=%0d we_n=%b oe=%b exp 2/1/0",
                           bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_oe);
    end
    tick();
    checks++;
    if (bus.SRAM_ADDR !== 18'd3 || bus.read_data[15:0] !== 16'hBEEF) begin
      failures++; $display("FAIL rd_hi got addr=%0d rd_lo=%h exp 3/beef", bus.SRAM_ADDR, bus.read_data[15:0]);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_done got ready=%b data=%h exp 1/deadbeef", bus.ready, bus.read_data);
    end
    tick();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.ready !== 1'b1 || bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0 ||
          bus.read_data !== 32'hDEADBEEF) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL idle_cycles got bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int bad;
    done_cnt = 0;
    bad = 0;
    bus.MEM_R_EN = 1'b1; bus.ALU_result = 32'd1028;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (bus.ready !== ((c % 6) == 5)) bad++;
      if (bus.ready === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL freeze_pattern got bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (done_cnt !== 2) begin
      failures++; $display("FAIL freeze_done_pulses got=%0d exp=2", done_cnt);
    end
    clear_inputs();
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL freeze_end got ready=%b data=%h exp 1/deadbeef", bus.ready, bus.read_data);
    end
    tick();
  endtask

  task automatic test_both_requests();
    bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b1;
    bus.ALU_result = 32'd1032; bus.ST_val = 32'h12345678;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.SRAM_ADDR !== 18'd4 || bus.SRAM_WE_N !== 1'b0 || bus.SRAM_DQ_out !== 16'h5678) begin
      failures++; $display("FAIL both_lo got addr=%0d we_n=%b dq=%h exp 4/0/5678",
                           bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_out);
    end
    tick();
    checks++;
    if (bus.SRAM_ADDR !== 18'd5 || bus.SRAM_WE_N !== 1'b0 || bus.SRAM_DQ_out !== 16'h1234) begin
      failures++; $display("FAIL both_hi got addr=%0d we_n=%b dq=%h exp 5/0/1234",
                           bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_out);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL both_done got ready=%b data=%h exp 1/deadbeef", bus.ready, bus.read_data);
    end
    checks++;
    if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234) begin
      failures++; $display("FAIL both_mem got=%h_%h exp=1234_5678", mem[5], mem[4]);
    end
    tick();
  endtask

  task automatic test_mid_change();
    bus.MEM_R_EN = 1'b1; bus.ALU_result = 32'd1032;
    tick();   // ACC_LO
    tick();   // ACC_HI
    tick();   // WAIT, first cycle
    bus.ALU_result = 32'd2048; bus.MEM_W_EN = 1'b1; bus.ST_val = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.SRAM_ADDR !== 18'd5 || bus.SRAM_WE_N !== 1'b1) begin
      failures++; $display("FAIL mid_wait1 got addr=%0d we_n=%b exp 5/1", bus.SRAM_ADDR, bus.SRAM_WE_N);
    end
    tick();
    checks++;
    if (bus.SRAM_ADDR !== 18'd5 || bus.ready !== 1'b0) begin
      failures++; $display("FAIL mid_wait2 got addr=%0d ready=%b exp 5/0", bus.SRAM_ADDR, bus.ready);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'h12345678) begin
      failures++; $display("FAIL mid_done got ready=%b data=%h exp 1/12345678", bus.ready, bus.read_data);
    end
    tick();
  endtask

  task automatic test_abort();
    // Preload half-words 0 and 1 through a complete write.
    bus.MEM_W_EN = 1'b1; bus.ALU_result = 32'd1024; bus.ST_val = 32'h22221111;
    tick();
    clear_inputs();
    repeat (5) tick();
    // Second write to the same word, aborted during ACC_HI.
    bus.MEM_W_EN = 1'b1; bus.ALU_result = 32'd1024; bus.ST_val = 32'hCAFEF00D;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.SRAM_ADDR !== 18'd0 || bus.SRAM_WE_N !== 1'b0 || bus.SRAM_DQ_out !== 16'hF00D) begin
      failures++; $display("FAIL abort_lo got addr=%0d we_n=%b dq=%h exp 0/0/f00d",
                           bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_out);
    end
    tick();   // ACC_HI
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0 || bus.ready !== 1'b1) begin
      failures++; $display("FAIL abort_next got we_n=%b oe=%b ready=%b exp 1/0/1",
                           bus.SRAM_WE_N, bus.SRAM_DQ_oe, bus.ready);
    end
    tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.SRAM_WE_N !== 1'b1 || bus.read_data !== 32'd0) begin
      failures++; $display("FAIL abort_idle got ready=%b we_n=%b data=%h exp 1/1/0",
                           bus.ready, bus.SRAM_WE_N, bus.read_data);
    end
    checks++;
    if (mem[0] !== 16'hF00D || mem[1] !== 16'h2222) begin
      failures++; $display("FAIL abort_mem got=%h_%h exp=2222_f00d", mem[1], mem[0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_write_read();
    test_idle();
    test_back_to_back();
    test_both_requests();
    test_mid_change();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
